// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operation request in, result out.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [2:0]       nzp;
  logic             carry;

  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, result, nzp, carry
  );

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, result, nzp, carry
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, bit-serial shifts and
// shift-add multiply, with a valid/ready handshake on both sides.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;       // multiplicand, shifted left each MUL step
  logic [WIDTH-1:0] r_b;       // multiplier, shifted right each MUL step
  logic [WIDTH-1:0] r_acc;     // shift value or partial product
  logic [SHW:0]     r_cnt;
  logic [SHW:0]     r_tc;      // terminal count captured at accept
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_nzp;
  logic             r_carry;

  logic             w_accept;
  logic [SHW-1:0]   w_k;
  logic             w_multi;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_imm_res;
  logic             w_imm_carry;
  logic [WIDTH-1:0] w_step;
  logic             w_last;

  function automatic logic [2:0] f_nzp(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) return 3'b100;
    else if (v == '0) return 3'b010;
    else return 3'b001;
  endfunction

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_k      = bus.B[SHW-1:0];
  assign w_multi  = (bus.op == OP_MUL) ||
                    (((bus.op == OP_SHL) || (bus.op == OP_SHR)) && (w_k != '0));
  assign w_sum    = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_diff   = {1'b0, bus.A} + {1'b0, ~bus.B} + (WIDTH+1)'(1);
  assign w_last   = (r_cnt == r_tc);

  // Single-cycle results; zero-length shifts fall through as PASS.
  always_comb begin
    w_imm_res   = bus.A;
    w_imm_carry = 1'b0;
    case (bus.op)
      OP_ADD: begin
        w_imm_res   = w_sum[WIDTH-1:0];
        w_imm_carry = w_sum[WIDTH];
      end
      OP_AND:  w_imm_res = bus.A & bus.B;
      OP_NOT:  w_imm_res = ~bus.A;
      OP_PASS: w_imm_res = bus.A;
      OP_SUB: begin
        w_imm_res   = w_diff[WIDTH-1:0];
        w_imm_carry = w_diff[WIDTH];
      end
      default: ;
    endcase
  end

  // One iteration of a serial shift or a shift-add multiply step.
  always_comb begin
    w_step = r_acc;
    case (r_op)
      OP_SHL:  w_step = r_acc << 1;
      OP_SHR:  w_step = r_acc >> 1;
      OP_MUL:  if (r_b[0]) w_step = r_acc + r_a;
      default: ;
    endcase
  end

  // Control FSM plus datapath registers; outputs change only on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_tc     <= '0;
      r_result <= '0;
      r_nzp    <= 3'b010;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op  <= bus.op;
            r_a   <= bus.A;
            r_b   <= bus.B;
            r_cnt <= '0;
            if (w_multi) begin
              r_state <= BUSY;
              r_acc   <= (bus.op == OP_MUL) ? '0 : bus.A;
              r_tc    <= (bus.op == OP_MUL) ? (SHW+1)'(WIDTH - 1)
                                            : {1'b0, w_k} - (SHW+1)'(1);
            end else begin
              r_state  <= DONE;
              r_result <= w_imm_res;
              r_nzp    <= f_nzp(w_imm_res);
              r_carry  <= w_imm_carry;
            end
          end
        end
        BUSY: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + (SHW+1)'(1);
          if (r_op == OP_MUL) begin
            r_a <= r_a << 1;
            r_b <= r_b >> 1;
          end
          if (w_last) begin
            r_state  <= DONE;
            r_result <= w_step;
            r_nzp    <= f_nzp(w_step);
            r_carry  <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.nzp       = r_nzp;
  assign bus.carry     = r_carry;
endmodule
